tmds_channel_encoder: RTL and testbench



---
 rtl/tmds_channel_encoder.sv | 183 ++++++++++++++++++
 tb/tb_tmds_channel_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_encoder.sv
// Per-lane TMDS 8b/10b encoder: DVI video encoding with running disparity, control codes,
// and HDMI TERC4 data-island codes when built with `define TMDS_TERC4_EN.
module tmds_channel_encoder #(
  parameter int unsigned INVERT_OUT = 0,
  parameter int unsigned MSB_FIRST  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       de,
  input  logic [7:0] d,
  input  logic [1:0] c,
  input  logic       aux_en,
  input  logic [3:0] aux,
  output logic [9:0] q_out
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 10;
  localparam int unsigned CW = 5;

  localparam logic [SW-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SW-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SW-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SW-1:0] CTRL_11 = 10'b1010101011;

  function automatic logic [SW-1:0] ctrl_code(input logic [1:0] cc);
    logic [SW-1:0] r;
    case (cc)
      2'b00:   r = CTRL_00;
      2'b01:   r = CTRL_01;
      2'b10:   r = CTRL_10;
      default: r = CTRL_11;
    endcase
    return r;
  endfunction

  // Board-level lane polarity and serializer bit order, applied to the final symbol.
  function automatic logic [SW-1:0] sym_out(input logic [SW-1:0] raw);
    logic [SW-1:0] v;
    logic [SW-1:0] r;
    v = (INVERT_OUT != 0) ? ~raw : raw;
    r = v;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < int'(SW); i++) r[i] = v[int'(SW)-1-i];
    end
    return r;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [SW-1:0] terc4(input logic [3:0] a);
    logic [SW-1:0] r;
    case (a)
      4'h0:    r = 10'b1010011100;
      4'h1:    r = 10'b1001100011;
      4'h2:    r = 10'b1011100100;
      4'h3:    r = 10'b1011100010;
      4'h4:    r = 10'b0101110001;
      4'h5:    r = 10'b0100011110;
      4'h6:    r = 10'b0110001110;
      4'h7:    r = 10'b0100111100;
      4'h8:    r = 10'b1011001100;
      4'h9:    r = 10'b0100111001;
      4'hA:    r = 10'b0110011100;
      4'hB:    r = 10'b1011000110;
      4'hC:    r = 10'b1010001110;
      4'hD:    r = 10'b1001110001;
      4'hE:    r = 10'b0101100011;
      default: r = 10'b1011000011;
    endcase
    return r;
  endfunction

  logic       aux_en_q, aux_en_m_q;
  logic [3:0] aux_q, aux_m_q;
`else
  logic unused_aux;
  assign unused_aux = ^{aux_en, aux};
`endif

  logic [DW-1:0]   d_q;
  logic            de_q, de_m_q;
  logic [1:0]      c_q, c_m_q;
  logic [3:0]      n1d;
  logic            use_xnor;
  logic [DW:0]     q_m_d, q_m_q;
  logic [3:0]      n1;
  logic signed [CW-1:0] diff, cnt_d, cnt_q;
  logic [SW-1:0]   raw_d, q_out_q;

  // Input capture stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q  <= '0;
      de_q <= 1'b0;
      c_q  <= '0;
`ifdef TMDS_TERC4_EN
      aux_en_q <= 1'b0;
      aux_q    <= '0;
`endif
    end else begin
      d_q  <= d;
      de_q <= de;
      c_q  <= c;
`ifdef TMDS_TERC4_EN
      aux_en_q <= aux_en;
      aux_q    <= aux;
`endif
    end
  end

  // Transition-minimising q_m: XNOR chain when the byte is ones-heavy.
  always_comb begin
    n1d = '0;
    for (int i = 0; i < int'(DW); i++) n1d = n1d + 4'(d_q[i]);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d_q[0]);
    q_m_d    = '0;
    q_m_d[0] = d_q[0];
    for (int i = 1; i < int'(DW); i++) begin
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ d_q[i]) : (q_m_d[i-1] ^ d_q[i]);
    end
    q_m_d[DW] = ~use_xnor;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_m_q  <= '0;
      de_m_q <= 1'b0;
      c_m_q  <= '0;
`ifdef TMDS_TERC4_EN
      aux_en_m_q <= 1'b0;
      aux_m_q    <= '0;
`endif
    end else begin
      q_m_q  <= q_m_d;
      de_m_q <= de_q;
      c_m_q  <= c_q;
`ifdef TMDS_TERC4_EN
      aux_en_m_q <= aux_en_q;
      aux_m_q    <= aux_q;
`endif
    end
  end

  // DC balance: diff = n1 - n0 of q_m[7:0], kept in 5-bit two's complement.
  always_comb begin
    n1 = '0;
    for (int i = 0; i < int'(DW); i++) n1 = n1 + 4'(q_m_q[i]);
    diff  = $signed(({1'b0, n1} << 1) - 5'd8);
    raw_d = ctrl_code(c_m_q);
    cnt_d = '0;
    if (de_m_q) begin
      if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
        raw_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
        cnt_d = q_m_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                   ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
        raw_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
        cnt_d = cnt_q + (q_m_q[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        raw_d = {1'b0, q_m_q[8], q_m_q[7:0]};
        cnt_d = cnt_q - (q_m_q[8] ? 5'sd0 : 5'sd2) + diff;
      end
    end
`ifdef TMDS_TERC4_EN
    else if (aux_en_m_q) begin
      raw_d = terc4(aux_m_q);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_out_q <= sym_out(CTRL_00);
      cnt_q   <= '0;
    end else begin
      q_out_q <= sym_out(raw_d);
      cnt_q   <= cnt_d;
    end
  end

  assign q_out = q_out_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Randomised and directed bench for tmds_channel_encoder against a behavioural DVI model;
// three instances cover the INVERT_OUT / MSB_FIRST output options.
module tb_tmds_channel_encoder;

  typedef struct packed {
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
    logic       aux_en;
    logic [3:0] aux;
  } in_t;

  localparam logic [9:0] CTRL_LUT [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
`ifdef TMDS_TERC4_EN
  localparam logic [9:0] TERC4_LUT [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
`endif
  localparam logic [9:0] ZERO_SYM [4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
  localparam int         ZERO_CNT [4] = '{-8, 2, -6, 4};

  logic       clk, reset, de, aux_en;
  logic [7:0] d;
  logic [1:0] c;
  logic [3:0] aux;
  logic [9:0] q_plain, q_inv, q_both;

  int   n_checks, n_errors;
  int   m_cnt;
  int   last_q, last_cnt;
  in_t  hist[$];

  tmds_channel_encoder #(.INVERT_OUT(0), .MSB_FIRST(0)) u_dut (
    .clk(clk), .reset(reset), .de(de), .d(d), .c(c), .aux_en(aux_en), .aux(aux), .q_out(q_plain));
  tmds_channel_encoder #(.INVERT_OUT(1), .MSB_FIRST(0)) u_inv (
    .clk(clk), .reset(reset), .de(de), .d(d), .c(c), .aux_en(aux_en), .aux(aux), .q_out(q_inv));
  tmds_channel_encoder #(.INVERT_OUT(1), .MSB_FIRST(1)) u_both (
    .clk(clk), .reset(reset), .de(de), .d(d), .c(c), .aux_en(aux_en), .aux(aux), .q_out(q_both));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] xform(input logic [9:0] raw, input bit inv, input bit rev);
    logic [9:0] v, r;
    v = inv ? ~raw : raw;
    r = v;
    if (rev) for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] v, r;
    v = s[9] ? ~s[7:0] : s[7:0];
    r[0] = v[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    return r;
  endfunction

  // q_m[i] is the prefix parity of d[i:0], with odd bits flipped on the XNOR path.
  task automatic model_encode(input in_t x, output logic [9:0] sym);
    int   n1d, ones, bal, qm8;
    bit   use_xnor, p;
    logic [7:0] qm;
    sym = CTRL_LUT[x.c];
    if (x.de) begin
      n1d      = $countones(x.d);
      use_xnor = (n1d > 4) || (n1d == 4 && x.d[0] == 1'b0);
      p = 1'b0;
      for (int i = 0; i < 8; i++) begin
        p     = p ^ x.d[i];
        qm[i] = p ^ (use_xnor && (i % 2 == 1));
      end
      qm8  = use_xnor ? 0 : 1;
      ones = $countones(qm);
      bal  = 2 * ones - 8;
      if (m_cnt == 0 || bal == 0) begin
        sym   = {(qm8 == 0), (qm8 == 1), (qm8 == 1) ? qm : ~qm};
        m_cnt = m_cnt + ((qm8 == 1) ? bal : -bal);
      end else if ((m_cnt > 0 && bal > 0) || (m_cnt < 0 && bal < 0)) begin
        sym   = {1'b1, (qm8 == 1), ~qm};
        m_cnt = m_cnt + 2 * qm8 - bal;
      end else begin
        sym   = {1'b0, (qm8 == 1), qm};
        m_cnt = m_cnt - 2 * (1 - qm8) + bal;
      end
    end
`ifdef TMDS_TERC4_EN
    else if (x.aux_en) begin
      sym   = TERC4_LUT[x.aux];
      m_cnt = 0;
    end
`endif
    else begin
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(in_t'(0));
    hist.push_back(in_t'(0));
    m_cnt = 0;
  endtask

  // Called at a falling edge: drive, clock once, check the symbol from two edges earlier.
  task automatic step(input in_t x);
    in_t        e;
    logic [9:0] sym;
    int         dcnt;
    de = x.de; d = x.d; c = x.c; aux_en = x.aux_en; aux = x.aux;
    hist.push_back(x);
    @(posedge clk);
    #1;
    e = hist.pop_front();
    model_encode(e, sym);
    dcnt = int'(u_dut.cnt_q);
    check_eq("q_plain", int'(q_plain), int'(sym));
    check_eq("q_inv", int'(q_inv), int'(xform(sym, 1'b1, 1'b0)));
    check_eq("q_both", int'(q_both), int'(xform(sym, 1'b1, 1'b1)));
    check_eq("cnt", dcnt, m_cnt);
    check_eq("cnt_range", int'(dcnt >= -10 && dcnt <= 10), 1);
    if (e.de) check_eq("decode", int'(tmds_decode(q_plain)), int'(e.d));
    last_q   = int'(q_plain);
    last_cnt = dcnt;
    @(negedge clk);
  endtask

  in_t x;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    de = 1'b0; d = '0; c = '0; aux_en = 1'b0; aux = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_plain", int'(q_plain), 'h354);
    check_eq("rst_inv", int'(q_inv), 'h0AB);
    check_eq("rst_both", int'(q_both), 'h354);
    check_eq("rst_cnt", int'(u_dut.cnt_q), 0);
    reset = 1'b0;
    model_reset();

    // Idle control period.
    for (int i = 0; i < 4; i++) begin
      step(in_t'(0));
      check_eq("idle_sym", last_q, 'h354);
    end

    // Four all-zero pixels from cnt = 0.
    for (int i = 0; i < 6; i++) begin
      x = '0;
      if (i < 4) x.de = 1'b1;
      step(x);
      if (i >= 2) begin
        check_eq("zero_sym", last_q, int'(ZERO_SYM[i-2]));
        check_eq("zero_cnt", last_cnt, ZERO_CNT[i-2]);
      end
    end

    // Control codes for c = 00, 01, 10, 11.
    for (int i = 0; i < 6; i++) begin
      x = '0;
      x.c = 2'(i % 4);
      if (i >= 4) x.c = 2'b00;
      step(x);
      if (i >= 2) check_eq("ctrl_sym", last_q, int'(CTRL_LUT[i-2]));
    end
    check_eq("ctrl_cnt", last_cnt, 0);

    // Data-island nibbles 0..F with c = 01.
    for (int i = 0; i < 18; i++) begin
      x = '0;
      x.c = 2'b01;
      if (i < 16) begin
        x.aux_en = 1'b1;
        x.aux    = 4'(i);
      end
      step(x);
`ifdef TMDS_TERC4_EN
      if (i >= 2) check_eq("terc4_sym", last_q, int'(TERC4_LUT[i-2]));
`else
      if (i >= 2) check_eq("aux_ignored", last_q, 'h0AB);
`endif
    end

    // Shortened frame: 640-pixel active lines, 800 total, sync on c, islands in blanking.
    for (int ln = 0; ln < 10; ln++) begin
      for (int h = 0; h < 800; h++) begin
        x = '0;
        x.de     = (ln >= 3) && (h < 640);
        x.d      = 8'($urandom);
        x.c      = {(ln < 2), (h >= 656 && h < 752)};
        x.aux_en = !x.de && (h >= 680 && h < 712);
        x.aux    = 4'($urandom);
        if (!x.de) x.d = '0;
        step(x);
      end
    end

    // Asynchronous reset mid active line.
    for (int h = 0; h < 300; h++) begin
      x = '0;
      x.de = 1'b1;
      x.d  = 8'($urandom);
      step(x);
    end
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_plain", int'(q_plain), 'h354);
    check_eq("midrst_inv", int'(q_inv), 'h0AB);
    check_eq("midrst_cnt", int'(u_dut.cnt_q), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int h = 0; h < 200; h++) begin
      x = '0;
      x.de = 1'b1;
      x.d  = 8'($urandom);
      step(x);
      if (h < 2) check_eq("post_rst_ctrl", last_q, 'h354);
    end
    for (int i = 0; i < 4; i++) step(in_t'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
